// File: rtl/memory_access_pkg.sv
// memory_access_pkg
// Shared types for the MIPS memory stage: common scalar aliases, the
// execute->memory and memory->writeback pipeline bundles, the access-size
// encoding and the bus-access FSM states.
// Optional build macro affecting users of this package: MEM_SUBWORD_EN.
package memory_access_pkg;

  // Common aliases
  typedef logic [31:0] u32;
  typedef logic [4:0]  creg_addr_t;

  // Access size carried from execute (only honoured with MEM_SUBWORD_EN)
  typedef enum logic [1:0] {
    MSIZE_BYTE = 2'd0,
    MSIZE_HALF = 2'd1,
    MSIZE_WORD = 2'd2
  } msize_t;

  // Data-bus access progress
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no outstanding request
    ADDR = 2'd1,  // request presented, waiting for addr_ok
    DATA = 2'd2   // address accepted, waiting for data_ok
  } mem_state_t;

  typedef struct packed {
    u32         alu_result;
    u32         write_data;
    creg_addr_t write_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    msize_t     msize;
    logic       msign;
  } e_m_reg_t;

  typedef struct packed {
    u32         alu_result;
    u32         read_data;
    creg_addr_t write_reg;
    logic       reg_write;
    logic       mem_to_reg;
  } m_w_reg_t;

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if
// Data-memory bus with valid/addr_ok/data_ok handshake.
//   dreq_valid/dreq_write/dreq_addr/dreq_strobe/dreq_data : request (master drives)
//   dresp_addr_ok/dresp_data_ok/dresp_data                : response (slave drives)
// Modports: master (memory stage), slave (memory / bus model).
interface memory_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dreq_valid;
  logic              dreq_write;
  logic [ADDR_W-1:0] dreq_addr;
  logic [3:0]        dreq_strobe;
  logic [DATA_W-1:0] dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;

  modport master (
    output dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/memory_access_extend.sv
// mem_extend
// Combinational store lane/strobe generation and load lane extraction with
// sign/zero extension.
//   i_addr_lo    : byte address bits [1:0] from the ALU result
//   i_msize      : access size, i_msign : sign-extend loads
//   i_store_data : register value to store, i_load_data : raw bus word
//   o_addr_lo    : aligned address bits [1:0] to put on the bus
//   o_strobe     : byte-lane enables for a store (caller masks on loads)
//   o_store_data : lane-aligned store data, o_read_data : extended load value
// Macro MEM_SUBWORD_EN: byte/half accesses; otherwise word-only pass-through.
module mem_extend
  import memory_access_pkg::*;
(
  input  logic [1:0] i_addr_lo,
  input  msize_t     i_msize,
  input  logic       i_msign,
  input  u32         i_store_data,
  input  u32         i_load_data,
  output logic [1:0] o_addr_lo,
  output logic [3:0] o_strobe,
  output u32         o_store_data,
  output u32         o_read_data
);

`ifdef MEM_SUBWORD_EN
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane picks: byte by a[1:0], halfword by a[1] (a[0] treated as 0)
  assign w_byte = 8'(i_load_data >> {i_addr_lo, 3'b000});
  assign w_half = 16'(i_load_data >> {i_addr_lo[1], 4'b0000});

  always_comb begin
    o_addr_lo    = 2'b00;
    o_strobe     = 4'hF;
    o_store_data = i_store_data;
    o_read_data  = i_load_data;
    case (i_msize)
      MSIZE_BYTE: begin
        o_addr_lo    = i_addr_lo;
        o_strobe     = 4'b0001 << i_addr_lo;
        o_store_data = {4{i_store_data[7:0]}};
        o_read_data  = {{24{i_msign & w_byte[7]}}, w_byte};
      end
      MSIZE_HALF: begin
        // Misaligned halfword proceeds with a[0] dropped
        o_addr_lo    = {i_addr_lo[1], 1'b0};
        o_strobe     = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_store_data = {2{i_store_data[15:0]}};
        o_read_data  = {{16{i_msign & w_half[15]}}, w_half};
      end
      default: ;  // word (and unused encoding): full-word access
    endcase
  end
`else
  // Size/sign/low address bits have no effect in a word-only build
  logic w_unused;
  assign w_unused     = ^{i_addr_lo, i_msize, i_msign};
  assign o_addr_lo    = 2'b00;
  assign o_strobe     = 4'hF;
  assign o_store_data = i_store_data;
  assign o_read_data  = i_load_data;
`endif

endmodule

// File: rtl/memory_access.sv
// memory_access
// MIPS memory stage: registers the execute->memory bundle, runs the data
// access over the valid/addr_ok/data_ok bus and produces the writeback
// bundle, a stall request and the forwarding source.
//   clk, resetn     : clock, synchronous active-low reset
//   e_m_reg         : bundle from execute
//   bus (master)    : data-memory request/response
//   m_w_reg         : bundle to writeback (bubble while stalled)
//   mem_stall       : stage busy, upstream must hold
//   fwd_*           : forwarding source for execute
// Macro MEM_SUBWORD_EN: enables byte/halfword accesses in mem_extend.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  e_m_reg_t              e_m_reg,
  memory_access_if.master       bus,
  output m_w_reg_t              m_w_reg,
  output logic                  mem_stall,
  output logic                  fwd_reg_write,
  output creg_addr_t            fwd_write_reg,
  output u32                    fwd_result
);

  e_m_reg_t   r_e_m;
  mem_state_t r_state;
  mem_state_t w_state_next;
  logic       w_is_mem;
  logic       w_done;
  logic       w_stall;
  logic [1:0] w_addr_lo;
  logic [3:0] w_strobe;
  u32         w_store_data;
  u32         w_read_data;

  mem_extend u_extend (
    .i_addr_lo    (r_e_m.alu_result[1:0]),
    .i_msize      (r_e_m.msize),
    .i_msign      (r_e_m.msign),
    .i_store_data (r_e_m.write_data),
    .i_load_data  (32'(bus.dresp_data)),
    .o_addr_lo    (w_addr_lo),
    .o_strobe     (w_strobe),
    .o_store_data (w_store_data),
    .o_read_data  (w_read_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_e_m   <= '0;
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
      if (!w_stall) r_e_m <= e_m_reg;
    end
  end

  assign w_is_mem = r_e_m.mem_read | r_e_m.mem_write;
  // In DATA the address was already accepted, so only data_ok matters
  assign w_done   = w_is_mem && bus.dresp_data_ok &&
                    (r_state == DATA || bus.dresp_addr_ok);
  assign w_stall  = w_is_mem && !w_done;
  assign mem_stall = w_stall;

  always_comb begin
    w_state_next   = r_state;
    bus.dreq_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.dreq_valid = w_is_mem;
        // Responses with no memory instruction present are ignored
        if (w_is_mem) begin
          if (bus.dresp_addr_ok && bus.dresp_data_ok) w_state_next = IDLE;
          else if (bus.dresp_addr_ok)                 w_state_next = DATA;
          else                                        w_state_next = ADDR;
        end
      end
      ADDR: begin
        bus.dreq_valid = 1'b1;
        if (bus.dresp_addr_ok && bus.dresp_data_ok) w_state_next = IDLE;
        else if (bus.dresp_addr_ok)                 w_state_next = DATA;
      end
      DATA: begin
        if (bus.dresp_data_ok) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request fields come straight from r_e_m, which holds while stalled
  assign bus.dreq_write  = r_e_m.mem_write;
  assign bus.dreq_addr   = ADDR_W'({r_e_m.alu_result[31:2], w_addr_lo});
  assign bus.dreq_strobe = r_e_m.mem_write ? w_strobe : 4'h0;
  assign bus.dreq_data   = DATA_W'(w_store_data);

  always_comb begin
    m_w_reg = '0;
    if (!w_stall) begin
      m_w_reg.alu_result = r_e_m.alu_result;
      m_w_reg.read_data  = r_e_m.mem_read ? w_read_data : 32'h0;
      m_w_reg.write_reg  = r_e_m.write_reg;
      m_w_reg.reg_write  = r_e_m.reg_write;
      m_w_reg.mem_to_reg = r_e_m.mem_to_reg;
    end
  end

  assign fwd_reg_write = m_w_reg.reg_write;
  assign fwd_write_reg = m_w_reg.write_reg;
  assign fwd_result    = m_w_reg.mem_to_reg ? m_w_reg.read_data : m_w_reg.alu_result;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access
// Directed bench for memory_access: reset, multi-cycle load, single-cycle
// store, ALU pass-through, long address stall, reset during DATA, and
// subword accesses when MEM_SUBWORD_EN is defined (word alignment otherwise).
module tb_memory_access;
  import memory_access_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  e_m_reg_t   e_m_reg;
  m_w_reg_t   m_w_reg;
  logic       mem_stall;
  logic       fwd_reg_write;
  creg_addr_t fwd_write_reg;
  u32         fwd_result;
  int         checks = 0;
  int         errors = 0;

  memory_access_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  memory_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .e_m_reg       (e_m_reg),
    .bus           (bus),
    .m_w_reg       (m_w_reg),
    .mem_stall     (mem_stall),
    .fwd_reg_write (fwd_reg_write),
    .fwd_write_reg (fwd_write_reg),
    .fwd_result    (fwd_result)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after posedge; checks sample 1 unit later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic bus_resp(input logic aok, input logic dok, input u32 data);
    bus.dresp_addr_ok = aok;
    bus.dresp_data_ok = dok;
    bus.dresp_data    = data;
  endtask

  function automatic e_m_reg_t mk(input u32 alu, input u32 wd, input creg_addr_t wr,
                                  input logic rw, input logic mr, input logic mw,
                                  input logic m2r, input msize_t sz, input logic sg);
    e_m_reg_t e;
    e.alu_result = alu;  e.write_data = wd;  e.write_reg = wr;
    e.reg_write  = rw;   e.mem_read   = mr;  e.mem_write = mw;
    e.mem_to_reg = m2r;  e.msize      = sz;  e.msign     = sg;
    return e;
  endfunction

  initial begin
    resetn  = 1'b0;
    e_m_reg = '0;
    bus_resp(1'b0, 1'b0, 32'h0);

    // ---- reset state
    tick(); tick();
    resetn = 1'b1;
    #1;
    chk("rst_mw",    32'(m_w_reg), 32'h0);
    chk("rst_valid", 32'(bus.dreq_valid), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    $display("txn reset done");

    // ---- lw $9, 0x100 : addr_ok cycle 1, data_ok cycle 3
    e_m_reg = mk(32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, MSIZE_WORD, 1'b0);
    tick();                                   // cycle 0
    e_m_reg = '0;
    bus_resp(1'b0, 1'b0, 32'h0);
    #1;
    chk("lw_c0_stall", 32'(mem_stall), 32'h1);
    chk("lw_c0_valid", 32'(bus.dreq_valid), 32'h1);
    chk("lw_c0_addr",  bus.dreq_addr, 32'h100);
    chk("lw_c0_strb",  32'(bus.dreq_strobe), 32'h0);
    chk("lw_c0_rw",    32'(m_w_reg.reg_write), 32'h0);
    tick();                                   // cycle 1
    bus_resp(1'b1, 1'b0, 32'h0);
    #1;
    chk("lw_c1_stall", 32'(mem_stall), 32'h1);
    chk("lw_c1_valid", 32'(bus.dreq_valid), 32'h1);
    tick();                                   // cycle 2
    bus_resp(1'b0, 1'b0, 32'h0);
    #1;
    chk("lw_c2_stall", 32'(mem_stall), 32'h1);
    chk("lw_c2_valid", 32'(bus.dreq_valid), 32'h0);
    tick();                                   // cycle 3
    bus_resp(1'b0, 1'b1, 32'hDEADBEEF);
    e_m_reg = mk(32'h104, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MSIZE_WORD, 1'b0);
    #1;
    chk("lw_c3_stall", 32'(mem_stall), 32'h0);
    chk("lw_c3_rw",    32'(m_w_reg.reg_write), 32'h1);
    chk("lw_c3_rdata", m_w_reg.read_data, 32'hDEADBEEF);
    chk("lw_c3_fwd",   fwd_result, 32'hDEADBEEF);
    chk("lw_c3_fwreg", 32'(fwd_write_reg), 32'd9);
    $display("txn lw 0x100 -> 0x%08h", m_w_reg.read_data);

    // ---- sw 0x12345678 to 0x104, accepted and completed in cycle 0
    tick();
    bus_resp(1'b1, 1'b1, 32'h0);
    e_m_reg = mk(32'h55, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, MSIZE_WORD, 1'b0);
    #1;
    chk("sw_valid", 32'(bus.dreq_valid), 32'h1);
    chk("sw_write", 32'(bus.dreq_write), 32'h1);
    chk("sw_addr",  bus.dreq_addr, 32'h104);
    chk("sw_strb",  32'(bus.dreq_strobe), 32'hF);
    chk("sw_data",  bus.dreq_data, 32'h12345678);
    chk("sw_stall", 32'(mem_stall), 32'h0);
    chk("sw_rw",    32'(m_w_reg.reg_write), 32'h0);
    $display("txn sw 0x104 strobe=%h", bus.dreq_strobe);

    // ---- addu $8 = 0x55, with a stray data_ok that must be ignored
    tick();
    bus_resp(1'b0, 1'b1, 32'hFFFFFFFF);
    e_m_reg = mk(32'h200, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, MSIZE_WORD, 1'b0);
    #1;
    chk("alu_res",   m_w_reg.alu_result, 32'h55);
    chk("alu_rw",    32'(m_w_reg.reg_write), 32'h1);
    chk("alu_fwd",   fwd_result, 32'h55);
    chk("alu_fwrw",  32'(fwd_reg_write), 32'h1);
    chk("alu_fwreg", 32'(fwd_write_reg), 32'd8);
    chk("alu_valid", 32'(bus.dreq_valid), 32'h0);
    chk("alu_stall", 32'(mem_stall), 32'h0);
    $display("txn addu -> 0x%08h", fwd_result);

    // ---- lw 0x200 held 4 cycles waiting for addr_ok, upstream keeps changing
    for (int i = 0; i < 4; i++) begin
      tick();
      bus_resp(1'b0, 1'b0, 32'h0);
      e_m_reg = mk(32'h1000 + 32'(i * 4), 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, MSIZE_WORD, 1'b0);
      #1;
      chk("hold_addr",  bus.dreq_addr, 32'h200);
      chk("hold_valid", 32'(bus.dreq_valid), 32'h1);
      chk("hold_stall", 32'(mem_stall), 32'h1);
      chk("hold_rw",    32'(m_w_reg.reg_write), 32'h0);
      $display("txn hold cycle %0d addr=0x%08h", i, bus.dreq_addr);
    end
    tick();
    bus_resp(1'b1, 1'b1, 32'hCAFEF00D);
    e_m_reg = mk(32'h300, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, MSIZE_WORD, 1'b0);
    #1;
    chk("hold_done_stall", 32'(mem_stall), 32'h0);
    chk("hold_done_rdata", m_w_reg.read_data, 32'hCAFEF00D);
    chk("hold_done_wreg",  32'(m_w_reg.write_reg), 32'd10);
    $display("txn lw 0x200 -> 0x%08h", m_w_reg.read_data);

    // ---- lw 0x300 reaches DATA, then reset
    tick();
    bus_resp(1'b1, 1'b0, 32'h0);
    e_m_reg = '0;
    #1;
    chk("rd_c0_valid", 32'(bus.dreq_valid), 32'h1);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    e_m_reg = mk(32'h77, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, MSIZE_WORD, 1'b0);
    #1;
    chk("rd_c1_valid", 32'(bus.dreq_valid), 32'h0);
    chk("rd_c1_stall", 32'(mem_stall), 32'h1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    e_m_reg = mk(32'h400, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, MSIZE_WORD, 1'b0);
    #1;
    chk("rst_mid_valid", 32'(bus.dreq_valid), 32'h0);
    chk("rst_mid_stall", 32'(mem_stall), 32'h0);
    chk("rst_mid_rw",    32'(m_w_reg.reg_write), 32'h0);
    $display("txn reset during DATA");
    // A fresh load must start from IDLE: request visible and done in one cycle
    tick();
    bus_resp(1'b1, 1'b1, 32'h00001234);
    e_m_reg = '0;
    #1;
    chk("post_rst_valid", 32'(bus.dreq_valid), 32'h1);
    chk("post_rst_stall", 32'(mem_stall), 32'h0);
    chk("post_rst_rdata", m_w_reg.read_data, 32'h00001234);
    $display("txn lw 0x400 -> 0x%08h", m_w_reg.read_data);

`ifdef MEM_SUBWORD_EN
    // ---- lb 0x103 (signed) and sb 0x102
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    e_m_reg = mk(32'h103, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, MSIZE_BYTE, 1'b1);
    tick();
    bus_resp(1'b1, 1'b1, 32'h80000000);
    e_m_reg = mk(32'h102, 32'h000000AB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MSIZE_BYTE, 1'b0);
    #1;
    chk("lb_addr",  bus.dreq_addr, 32'h103);
    chk("lb_rdata", m_w_reg.read_data, 32'hFFFFFF80);
    $display("txn lb 0x103 -> 0x%08h", m_w_reg.read_data);
    tick();
    bus_resp(1'b1, 1'b1, 32'h0);
    e_m_reg = '0;
    #1;
    chk("sb_strb", 32'(bus.dreq_strobe), 32'h4);
    chk("sb_data", bus.dreq_data, 32'hABABABAB);
    $display("txn sb 0x102 strobe=%h", bus.dreq_strobe);
`else
    // ---- word-only build: low address bits forced to zero, data unextended
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    e_m_reg = mk(32'h103, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, MSIZE_BYTE, 1'b1);
    tick();
    bus_resp(1'b1, 1'b1, 32'h80000000);
    e_m_reg = '0;
    #1;
    chk("wo_addr",  bus.dreq_addr, 32'h100);
    chk("wo_rdata", m_w_reg.read_data, 32'h80000000);
    $display("txn lw 0x103 -> addr 0x%08h data 0x%08h", bus.dreq_addr, m_w_reg.read_data);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
MIPS pipeline memory stage, directly upstream of writeback. Registers the execute→memory bundle and performs the data-memory access over a valid/addr_ok/data_ok bus. Produces the memory→writeback bundle consumed by writeback, a stall request for the hazard unit, and the forwarding source. Loads and stores may take any number of bus cycles; non-memory instructions pass through in zero extra cycles.

Parameters:
ADDR_W, 32, data-bus address width
DATA_W, 32, data-bus data width (fixed 32 for MIPS; parameter for width checks only)

Ports:
clk  in  1  clock, all state updates on posedge
resetn  in  1  synchronous active-low reset
e_m_reg  in  e_m_reg_t  bundle from execute (alu_result, write_data, write_reg, reg_write, mem_read, mem_write, mem_to_reg, msize, msign)
dreq_valid  out  1  data request valid
dreq_write  out  1  1 = store, 0 = load
dreq_addr  out  ADDR_W  byte address (= alu_result)
dreq_strobe  out  4  byte-lane write enables; 0 on loads
dreq_data  out  DATA_W  store data, lane-aligned
dresp_addr_ok  in  1  bus accepted request
dresp_data_ok  in  1  load data valid / store complete
dresp_data  in  DATA_W  load data
m_w_reg  out  m_w_reg_t  bundle to writeback (alu_result, read_data, write_reg, reg_write, mem_to_reg)
mem_stall  out  1  stage busy; upstream must hold
fwd_reg_write, fwd_write_reg, fwd_result  out  1/5/32  forwarding source for execute

Behaviour:
- Input register e_m: on posedge, if !resetn → bubble (all control bits 0, data 0); else if !mem_stall → e_m <= e_m_reg; else hold.
- FSM mem_state_t {IDLE, ADDR, DATA}; reset → IDLE.
- is_mem = e_m.mem_read | e_m.mem_write.
- IDLE: dreq_valid = is_mem. If addr_ok && data_ok → stay IDLE (access done this cycle). If addr_ok only → DATA. If no addr_ok → ADDR.
- ADDR: dreq_valid=1, request fields held stable. addr_ok&&data_ok → IDLE; addr_ok → DATA.
- DATA: dreq_valid=0; data_ok → IDLE.
- done = is_mem && dresp_data_ok && (state==DATA || dresp_addr_ok). mem_stall = is_mem && !done (combinational).
- data_ok in IDLE with is_mem=0 is ignored.
- m_w_reg: if mem_stall → bubble (reg_write=0, mem_to_reg=0); else fields from e_m, read_data = extended dresp_data (loads), 0 otherwise.
- Non-memory instruction: zero added latency, m_w_reg valid same cycle it is in e_m.
- fwd_result = mem_to_reg ? read_data : alu_result; fwd_reg_write = m_w_reg.reg_write.
- Reset mid-access: next cycle state IDLE, dreq_valid 0, e_m bubble; bus is reset in the same cycle, no late responses expected.
- Default (no optional feature): word access only; dreq_addr low 2 bits forced to 0, strobe 4'hF on store, read_data = dresp_data.

Optional Feature:
MEM_SUBWORD_EN defined: msize {BYTE, HALF, WORD} and msign honoured. Store: data replicated to lanes, strobe = 1<<a[1:0] (byte), 3<<a[1:0] (half, a[0]=0), 4'hF (word). Load: lane selected by a[1:0], sign/zero-extended per msign. Misaligned half/word: access proceeds, address low bits forced aligned. Not defined: msize/msign ignored, word-only behaviour above.

Decomposition:
- pipes package: e_m_reg_t, m_w_reg_t, mem_state_t, msize_t.
- common package: u32, creg_addr_t.
- One sub-module mem_extend: combinational store strobe/lane generation and load extraction/extension; word-only pass-through when MEM_SUBWORD_EN undefined.

Test Plan:
- lw addr 0x100, addr_ok cycle 1, data_ok cycle 3, data 0xDEADBEEF → mem_stall high cycles 0-2, low cycle 3; m_w_reg reg_write=1, read_data=0xDEADBEEF in cycle 3.
- sw addr 0x104 data 0x12345678, addr_ok+data_ok cycle 0 → dreq_write=1, strobe 4'hF, mem_stall never high, m_w_reg reg_write=0.
- addu result 0x55 to $t0 → m_w_reg.alu_result=0x55, reg_write=1, fwd_result=0x55 same cycle, no dreq_valid.
- lw held in ADDR 4 cycles with e_m_reg changing → dreq_addr/e_m stable, m_w_reg bubble throughout.
- resetn low while in DATA → next cycle state IDLE, dreq_valid=0, m_w_reg.reg_write=0.
- MEM_SUBWORD_EN: lb addr 0x103 data 0x80000000 → read_data 0xFFFFFF80; sb addr 0x102 → strobe 4'b0100.
